// File: rtl/alu_status_reg.sv
// rtl/alu_status_reg.sv - ALU output stage: result pipeline register, NZVC flag register, sticky overflow and condition evaluation
module alu_status_reg #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     op_result,
    input  logic             negative,
    input  logic             zero,
    input  logic             overflow,
    input  logic             cout,
    input  logic             flags_we,
    input  logic             sticky_clr,
    input  logic [3:0]       cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c,
    output logic             sticky_v,
    output logic [CNT_W-1:0] ovf_count,
    output logic             cond_true
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic accept;
    logic ovf_event;
    logic n_eq_v;

    // A free slot or a slot being drained this cycle can take a new result.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign ovf_event = accept && flags_we && overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= op_result;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_c <= 1'b0;
        end else if (accept && flags_we) begin
            flag_n <= negative;
            flag_z <= zero;
            flag_v <= overflow;
            flag_c <= cout;
        end
    end

    // A new overflow event in the clearing cycle is counted as the first one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_v  <= 1'b0;
            ovf_count <= '0;
        end else if (sticky_clr) begin
            sticky_v  <= ovf_event;
            ovf_count <= ovf_event ? CNT_ONE : '0;
        end else if (ovf_event) begin
            sticky_v  <= 1'b1;
            if (ovf_count != CNT_MAX) begin
                ovf_count <= ovf_count + CNT_ONE;
            end
        end
    end

    assign n_eq_v = (flag_n == flag_v);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'h0: cond_true = flag_z;
            4'h1: cond_true = !flag_z;
            4'h2: cond_true = flag_c;
            4'h3: cond_true = !flag_c;
            4'h4: cond_true = flag_n;
            4'h5: cond_true = !flag_n;
            4'h6: cond_true = flag_v;
            4'h7: cond_true = !flag_v;
            4'h8: cond_true = flag_c && !flag_z;
            4'h9: cond_true = !flag_c || flag_z;
            4'hA: cond_true = n_eq_v;
            4'hB: cond_true = !n_eq_v;
            4'hC: cond_true = !flag_z && n_eq_v;
            4'hD: cond_true = flag_z || !n_eq_v;
            4'hE: cond_true = 1'b1;
            4'hF: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_status_reg.sv
// tb/tb_alu_status_reg.sv - randomized and directed bench for alu_status_reg against a behavioural model
module tb_alu_status_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, negative, zero, overflow, cout, flags_we, sticky_clr, out_ready;
    logic [3:0] op_result, cond;

    logic       in_ready, out_valid, flag_n, flag_z, flag_v, flag_c, sticky_v, cond_true;
    logic [3:0] out_result;
    logic [7:0] ovf_count;

    logic       in_ready_s, out_valid_s, flag_n_s, flag_z_s, flag_v_s, flag_c_s, sticky_v_s, cond_true_s;
    logic [3:0] out_result_s;
    logic [1:0] ovf_count_s;

    int n_checks = 0;
    int n_fail   = 0;

    bit m_valid, m_n, m_z, m_v, m_c, m_sticky;
    int m_res, m_cnt, m_cnt_s;

    always #5 clk = ~clk;

    alu_status_reg #(.W(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_result(op_result), .negative(negative), .zero(zero), .overflow(overflow),
        .cout(cout), .flags_we(flags_we), .sticky_clr(sticky_clr), .cond(cond),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c),
        .sticky_v(sticky_v), .ovf_count(ovf_count), .cond_true(cond_true)
    );

    alu_status_reg #(.W(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .op_result(op_result), .negative(negative), .zero(zero), .overflow(overflow),
        .cout(cout), .flags_we(flags_we), .sticky_clr(sticky_clr), .cond(cond),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_result(out_result_s),
        .flag_n(flag_n_s), .flag_z(flag_z_s), .flag_v(flag_v_s), .flag_c(flag_c_s),
        .sticky_v(sticky_v_s), .ovf_count(ovf_count_s), .cond_true(cond_true_s)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond_eval(input int cc, input bit n, input bit z, input bit v, input bit c);
        case (cc)
            0:  return z;
            1:  return !z;
            2:  return c;
            3:  return !c;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return c && !z;
            9:  return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_all();
        chk("out_valid", out_valid, m_valid);
        if (m_valid) chk("out_result", out_result, m_res);
        chk("in_ready", in_ready, !m_valid || out_ready);
        chk("flags", {flag_n, flag_z, flag_v, flag_c}, {m_n, m_z, m_v, m_c});
        chk("sticky_v", sticky_v, m_sticky);
        chk("ovf_count", ovf_count, m_cnt);
        chk("cond_true", cond_true, cond_eval(cond, m_n, m_z, m_v, m_c));
        chk("out_valid_s", out_valid_s, m_valid);
        if (m_valid) chk("out_result_s", out_result_s, m_res);
        chk("in_ready_s", in_ready_s, !m_valid || out_ready);
        chk("sticky_v_s", sticky_v_s, m_sticky);
        chk("ovf_count_s", ovf_count_s, m_cnt_s);
        chk("cond_true_s", cond_true_s, cond_eval(cond, m_n, m_z, m_v, m_c));
    endtask

    task automatic model_reset();
        m_valid = 0; m_res = 0; m_n = 0; m_z = 0; m_v = 0; m_c = 0;
        m_sticky = 0; m_cnt = 0; m_cnt_s = 0;
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic step(input bit iv, input int res, input bit n, input bit z, input bit v,
                        input bit c, input bit we, input bit clr, input bit ordy, input int cc);
        bit acc, ev;
        in_valid = iv; op_result = res[3:0]; negative = n; zero = z; overflow = v; cout = c;
        flags_we = we; sticky_clr = clr; out_ready = ordy; cond = cc[3:0];
        acc = iv && (!m_valid || ordy);
        ev  = acc && we && v;
        @(posedge clk);
        if (acc) begin
            m_valid = 1; m_res = res;
        end else if (ordy) begin
            m_valid = 0;
        end
        if (acc && we) begin
            m_n = n; m_z = z; m_v = v; m_c = c;
        end
        if (clr) begin
            m_sticky = ev; m_cnt = ev ? 1 : 0; m_cnt_s = m_cnt;
        end else if (ev) begin
            m_sticky = 1;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", {flag_n, flag_z, flag_v, flag_c}, 0);
        chk("rst_ovf_count", ovf_count, 0);
        chk("rst_sticky", sticky_v, 0);
        chk("rst_ovf_count_s", ovf_count_s, 0);
        model_reset();
        in_valid = 0; flags_we = 0; sticky_clr = 0; out_ready = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        check_all();
    endtask

    initial begin
        int exp_s[4];
        int cc_list[6];
        int cc_exp[6];
        exp_s   = '{1, 2, 3, 3};
        cc_list = '{10, 11, 8, 13, 14, 15};
        cc_exp  = '{0, 1, 1, 1, 1, 0};

        rst_n = 1'b0;
        in_valid = 0; op_result = 0; negative = 0; zero = 0; overflow = 0; cout = 0;
        flags_we = 0; sticky_clr = 0; out_ready = 0; cond = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_all();
        @(negedge clk);

        // Three back-to-back results with a free-flowing sink.
        step(1, 3, 0, 0, 0, 0, 0, 0, 1, 14);
        chk("stream0", out_result, 3);
        step(1, 7, 0, 0, 0, 0, 0, 0, 1, 14);
        chk("stream1", out_result, 7);
        step(1, 12, 0, 0, 0, 0, 0, 0, 1, 14);
        chk("stream2", out_result, 12);
        chk("stream2_valid", out_valid, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 14);
        chk("stream_drain", out_valid, 0);

        // Backpressure then simultaneous consume and accept.
        step(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold", out_result, 5);
        end
        step(1, 9, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("bp_replace", out_result, 9);
        chk("bp_replace_valid", out_valid, 1);

        // Non-flag-setting op leaves flags and overflow state alone.
        do_reset();
        step(1, 1, 1, 0, 1, 0, 0, 0, 1, 0);
        chk("nowe_flags", {flag_n, flag_z, flag_v, flag_c}, 0);
        chk("nowe_sticky", sticky_v, 0);
        chk("nowe_count", ovf_count, 0);

        // Narrow counter saturation, then clear colliding with an event.
        for (int i = 0; i < 4; i++) begin
            step(1, i, 0, 0, 1, 0, 1, 0, 1, 6);
            chk("sat_s", ovf_count_s, exp_s[i]);
        end
        step(1, 4, 0, 0, 1, 0, 1, 1, 1, 6);
        chk("clr_ev_s", ovf_count_s, 1);
        chk("clr_ev_sticky_s", sticky_v_s, 1);
        chk("clr_ev_big", ovf_count, 1);

        // Condition codes against N=1 Z=0 V=0 C=1.
        step(1, 8, 1, 0, 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            cond = cc_list[i][3:0];
            #1 chk($sformatf("cond_%0h", cc_list[i]), cond_true, cc_exp[i]);
        end

        // Wide counter saturation.
        for (int i = 0; i < 260; i++) step(1, i & 15, 0, 0, 1, 0, 1, 0, 1, 6);
        chk("sat_big", ovf_count, 255);

        do_reset();
        for (int i = 0; i < 500; i++) begin
            step(($urandom % 4) != 0, $urandom % 16, $urandom % 2, $urandom % 2,
                 $urandom % 2, $urandom % 2, $urandom % 2, ($urandom % 20) == 0,
                 ($urandom % 10) < 7, $urandom % 16);
            if (i == 250) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
